ysyx_23060025_rd_burst_buf: RTL and testbench

Read-channel burst buffer between the crossbar's master-side read channels and the `io_master` AR/R ports. It registers one read address request and tracks one outstanding burst with a beat counter. Returned beats are held in a small FIFO so that upstream R backpressure never stalls the external bus combinationally. The block regenerates `last` from the requested length and raises a sticky error flag when the external slave's `rlast` disagrees.

---
 rtl/ysyx_23060025_rd_burst_buf.sv | 169 ++++++++++++++++
 tb/tb_ysyx_23060025_rd_burst_buf.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_rd_burst_buf.sv
// Read-channel burst buffer: registers one AR request toward io_master,
// tracks a single outstanding burst, buffers returned R beats in a small
// FIFO, regenerates rlast from the requested length and flags a sticky
// error whenever the slave's rlast disagrees with the regenerated one.
module ysyx_23060025_rd_burst_buf #(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic [ADDR_LEN-1:0] s_ar_addr_i,
  input  logic [7:0]          s_ar_len_i,
  input  logic [2:0]          s_ar_size_i,
  input  logic                s_ar_valid_i,
  output logic                s_ar_ready_o,
  output logic [DATA_LEN-1:0] s_r_data_o,
  output logic [1:0]          s_r_resp_o,
  output logic                s_r_last_o,
  output logic                s_r_valid_o,
  input  logic                s_r_ready_i,
  output logic [ADDR_LEN-1:0] m_ar_addr_o,
  output logic [7:0]          m_ar_len_o,
  output logic [2:0]          m_ar_size_o,
  output logic                m_ar_valid_o,
  input  logic                m_ar_ready_i,
  input  logic [DATA_LEN-1:0] m_r_data_i,
  input  logic [1:0]          m_r_resp_i,
  input  logic                m_r_last_i,
  input  logic                m_r_valid_i,
  output logic                m_r_ready_o,
  output logic                err_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN
  } state_t;

  state_t              state;
  logic [7:0]          beat_cnt;
  logic                ar_ready;
  logic                ar_valid;
  logic                err;

  logic [PW:0]         wr_ptr;
  logic [PW:0]         rd_ptr;
  logic [DATA_LEN-1:0] data_mem [DEPTH];
  logic [1:0]          resp_mem [DEPTH];
  logic                last_mem [DEPTH];

  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                last_calc;

  // FIFO status, handshakes and regenerated last
  always_comb begin
    full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    empty     = (wr_ptr == rd_ptr);
    last_calc = (beat_cnt == '0);
    push      = (state == DATA) && m_r_valid_i && !full;
    pop       = !empty && s_r_ready_i;
  end

  // Head entry drives the upstream R channel; zeros while empty so the
  // outputs read as their reset values between bursts
  always_comb begin
    s_r_valid_o = !empty;
    s_r_data_o  = '0;
    s_r_resp_o  = '0;
    s_r_last_o  = 1'b0;
    if (!empty) begin
      s_r_data_o = data_mem[rd_ptr[PW-1:0]];
      s_r_resp_o = resp_mem[rd_ptr[PW-1:0]];
      s_r_last_o = last_mem[rd_ptr[PW-1:0]];
    end
  end

  // Downstream ready depends only on FIFO room, never on upstream ready
  always_comb begin
    m_r_ready_o  = (state == DATA) && !full;
    s_ar_ready_o = ar_ready;
    m_ar_valid_o = ar_valid;
    err_o        = err;
  end

  // Burst FSM with registered AR handshake outputs, beat counter and sticky error
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      ar_ready    <= 1'b1;
      ar_valid    <= 1'b0;
      m_ar_addr_o <= '0;
      m_ar_len_o  <= '0;
      m_ar_size_o <= '0;
      beat_cnt    <= '0;
      err         <= 1'b0;
    end else begin
      if (push && (m_r_last_i != last_calc)) begin
        err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (s_ar_valid_i) begin
            m_ar_addr_o <= s_ar_addr_i;
            m_ar_len_o  <= s_ar_len_i;
            m_ar_size_o <= s_ar_size_i;
            beat_cnt    <= s_ar_len_i;
            ar_ready    <= 1'b0;
            ar_valid    <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (m_ar_ready_i) begin
            ar_valid <= 1'b0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (push) begin
            beat_cnt <= beat_cnt - 8'd1;
            if (last_calc) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && s_r_last_o) begin
            ar_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (PW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PW+1)'(1);
      end
    end
  end

  // FIFO storage; contents are only visible through the empty-gated head
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr[PW-1:0]] <= m_r_data_i;
      resp_mem[wr_ptr[PW-1:0]] <= m_r_resp_i;
      last_mem[wr_ptr[PW-1:0]] <= last_calc;
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_rd_burst_buf.sv
// Self-checking bench for ysyx_23060025_rd_burst_buf: a slave model feeds
// planned beats, a scoreboard holds expected upstream beats, and a monitor
// checks occupancy-derived flow control, error flag and beat contents.
module tb_ysyx_23060025_rd_burst_buf;

  localparam int unsigned DEPTH = 4;

  logic        clock;
  logic        rstn;
  logic [31:0] s_ar_addr_i;
  logic [7:0]  s_ar_len_i;
  logic [2:0]  s_ar_size_i;
  logic        s_ar_valid_i;
  logic        s_ar_ready_o;
  logic [31:0] s_r_data_o;
  logic [1:0]  s_r_resp_o;
  logic        s_r_last_o;
  logic        s_r_valid_o;
  logic        s_r_ready_i;
  logic [31:0] m_ar_addr_o;
  logic [7:0]  m_ar_len_o;
  logic [2:0]  m_ar_size_o;
  logic        m_ar_valid_o;
  logic        m_ar_ready_i;
  logic [31:0] m_r_data_i;
  logic [1:0]  m_r_resp_i;
  logic        m_r_last_i;
  logic        m_r_valid_i;
  logic        m_r_ready_o;
  logic        err_o;

  ysyx_23060025_rd_burst_buf #(
    .ADDR_LEN(32),
    .DATA_LEN(32),
    .DEPTH   (DEPTH)
  ) dut (
    .clock       (clock),
    .rstn        (rstn),
    .s_ar_addr_i (s_ar_addr_i),
    .s_ar_len_i  (s_ar_len_i),
    .s_ar_size_i (s_ar_size_i),
    .s_ar_valid_i(s_ar_valid_i),
    .s_ar_ready_o(s_ar_ready_o),
    .s_r_data_o  (s_r_data_o),
    .s_r_resp_o  (s_r_resp_o),
    .s_r_last_o  (s_r_last_o),
    .s_r_valid_o (s_r_valid_o),
    .s_r_ready_i (s_r_ready_i),
    .m_ar_addr_o (m_ar_addr_o),
    .m_ar_len_o  (m_ar_len_o),
    .m_ar_size_o (m_ar_size_o),
    .m_ar_valid_o(m_ar_valid_o),
    .m_ar_ready_i(m_ar_ready_i),
    .m_r_data_i  (m_r_data_i),
    .m_r_resp_i  (m_r_resp_i),
    .m_r_last_i  (m_r_last_i),
    .m_r_valid_i (m_r_valid_i),
    .m_r_ready_o (m_r_ready_o),
    .err_o       (err_o)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        slast;
    logic        elast;
  } plan_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  plan_t plan[$];
  exp_t  sb[$];

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  int unsigned taken    = 0;
  int unsigned first_pop_cyc = 0;
  int unsigned last_pop_cyc  = 0;
  bit          first_pop_seen = 0;
  bit          in_data = 0;
  bit          err_model = 0;
  bit          last_pop_pending = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Slave R model: presents the head of the plan after each rising edge
  always @(posedge clock) begin
    #1;
    if (plan.size() > 0) begin
      m_r_valid_i = 1'b1;
      m_r_data_i  = plan[0].data;
      m_r_resp_i  = plan[0].resp;
      m_r_last_i  = plan[0].slast;
    end else begin
      m_r_valid_i = 1'b0;
      m_r_data_i  = '0;
      m_r_resp_i  = '0;
      m_r_last_i  = 1'b0;
    end
  end

  // Monitor: checks state seen after the last edge, then records the
  // handshakes that will occur at the next edge
  always @(negedge clock) begin
    #1;
    if (rstn) begin
      check_eq("r_valid", s_r_valid_o, (sb.size() != 0));
      check_eq("m_r_ready", m_r_ready_o, in_data && (sb.size() < DEPTH));
      check_eq("err", err_o, err_model);
      if (s_r_valid_o && s_r_ready_i) begin
        if (sb.size() == 0) begin
          check_eq("pop_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("r_data", s_r_data_o, e.data);
          check_eq("r_resp", s_r_resp_o, e.resp);
          check_eq("r_last", s_r_last_o, e.last);
          if (!first_pop_seen) begin
            first_pop_seen = 1;
            first_pop_cyc  = cyc;
          end
          if (e.last) begin
            last_pop_pending = 1;
            last_pop_cyc     = cyc;
          end
        end
      end
      if (m_r_valid_i && m_r_ready_o && plan.size() > 0) begin
        plan_t p;
        exp_t  e;
        p = plan.pop_front();
        e.data = p.data;
        e.resp = p.resp;
        e.last = p.elast;
        sb.push_back(e);
        taken++;
        if (p.slast != p.elast) err_model = 1;
        if (p.elast) in_data = 0;
      end
    end
  end

  // Issue one AR upstream, handshake it downstream and load the slave plan
  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input int early_last,
                         input bit busy, input logic [31:0] base);
    int unsigned n = 0;
    last_pop_pending = 0;
    s_ar_addr_i  = addr;
    s_ar_len_i   = len;
    s_ar_size_i  = size;
    s_ar_valid_i = 1'b1;
    while (!s_ar_ready_o && n < 300) begin
      @(negedge clock);
      n++;
      if (busy) check_eq("ar_ready_busy", s_ar_ready_o, last_pop_pending);
    end
    if (n >= 300) check_eq("ar_accept_timeout", 0, 1);
    check_eq("m_ar_valid_pre", m_ar_valid_o, 0);
    @(negedge clock);
    s_ar_valid_i = 1'b0;
    check_eq("ar_ready_low", s_ar_ready_o, 0);
    check_eq("m_ar_valid", m_ar_valid_o, 1);
    check_eq("m_ar_addr", m_ar_addr_o, addr);
    check_eq("m_ar_len", m_ar_len_o, len);
    check_eq("m_ar_size", m_ar_size_o, size);
    @(negedge clock);
    check_eq("m_ar_valid_hold", m_ar_valid_o, 1);
    check_eq("m_ar_addr_hold", m_ar_addr_o, addr);
    m_ar_ready_i = 1'b1;
    @(negedge clock);
    m_ar_ready_i = 1'b0;
    check_eq("m_ar_valid_done", m_ar_valid_o, 0);
    taken = 0;
    first_pop_seen = 0;
    in_data = 1;
    for (int i = 0; i <= int'(len); i++) begin
      plan_t p;
      p.data  = base + 32'(i) * 32'h1111_1111;
      p.resp  = 2'(i % 4);
      p.elast = (i == int'(len));
      p.slast = (early_last >= 0) ? (i == early_last) : (i == int'(len));
      plan.push_back(p);
    end
  endtask

  task automatic wait_done(input int unsigned max);
    int unsigned n = 0;
    while (!(plan.size() == 0 && sb.size() == 0 && !in_data && s_ar_ready_o) && n < max) begin
      @(negedge clock);
      n++;
    end
    if (n >= max) check_eq("done_timeout", 0, 1);
    check_eq("idle_ar_ready", s_ar_ready_o, 1);
  endtask

  task automatic check_reset_values();
    check_eq("rst_ar_ready", s_ar_ready_o, 1);
    check_eq("rst_r_valid", s_r_valid_o, 0);
    check_eq("rst_m_ar_valid", m_ar_valid_o, 0);
    check_eq("rst_m_r_ready", m_r_ready_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_r_last", s_r_last_o, 0);
    check_eq("rst_m_ar_addr", m_ar_addr_o, 0);
    check_eq("rst_m_ar_len", m_ar_len_o, 0);
    check_eq("rst_m_ar_size", m_ar_size_o, 0);
    check_eq("rst_r_data", s_r_data_o, 0);
    check_eq("rst_r_resp", s_r_resp_o, 0);
  endtask

  initial begin
    rstn = 1'b0;
    s_ar_addr_i = '0; s_ar_len_i = '0; s_ar_size_i = '0; s_ar_valid_i = 1'b0;
    s_r_ready_i = 1'b1; m_ar_ready_i = 1'b0;
    m_r_data_i = '0; m_r_resp_i = '0; m_r_last_i = 1'b0; m_r_valid_i = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values();
    rstn = 1'b1;
    @(negedge clock);

    // single beat
    send_ar(32'h3000_0000, 8'd0, 3'd2, -1, 0, 32'hDEAD_BEEF);
    wait_done(100);
    check_eq("single_err", err_o, 0);

    // 4-beat burst at full throughput
    send_ar(32'h8000_1000, 8'd3, 3'd2, -1, 0, 32'h1000_0000);
    wait_done(100);
    check_eq("burst4_consecutive", last_pop_cyc - first_pop_cyc, 3);

    // backpressure: FIFO fills and downstream ready drops
    s_r_ready_i = 1'b0;
    send_ar(32'h8000_2000, 8'd7, 3'd2, -1, 0, 32'h2000_0000);
    repeat (15) @(negedge clock);
    check_eq("bp_taken", taken, DEPTH);
    check_eq("bp_m_r_ready", m_r_ready_o, 0);
    check_eq("bp_sb", sb.size(), DEPTH);
    s_r_ready_i = 1'b1;
    wait_done(200);
    check_eq("bp_all", taken, 8);

    // early rlast from slave on beat 2
    send_ar(32'h8000_3000, 8'd3, 3'd2, 1, 0, 32'h3000_0000);
    wait_done(100);
    check_eq("early_err", err_o, 1);

    // second request while busy waits for the first burst to drain
    send_ar(32'h8000_4000, 8'd3, 3'd1, -1, 0, 32'h4000_0000);
    send_ar(32'h8000_5000, 8'd1, 3'd2, -1, 1, 32'h5000_0000);
    wait_done(100);
    check_eq("busy_err_sticky", err_o, 1);

    // reset mid-burst after two beats
    send_ar(32'h8000_6000, 8'd3, 3'd2, -1, 0, 32'h6000_0000);
    begin
      int unsigned n = 0;
      while (taken < 2 && n < 100) begin
        @(negedge clock);
        n++;
      end
      if (n >= 100) check_eq("rst_wait_timeout", 0, 1);
    end
    rstn = 1'b0;
    plan.delete();
    sb.delete();
    in_data = 0;
    err_model = 0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clock);
    rstn = 1'b1;
    @(negedge clock);

    // fresh burst after reset
    send_ar(32'h8000_7000, 8'd2, 3'd2, -1, 0, 32'h7000_0000);
    wait_done(100);
    check_eq("post_rst_err", err_o, 0);
    check_eq("post_rst_beats", taken, 3);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
